// File: rtl/jk_reg_bank.sv
// Bank of JK bit cells with JK, count-up, count-down and parallel-load modes.
// Every mode is expressed as per-bit J/K drive into one shared cell update.
module jk_reg_bank #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             chg
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] q_next;

    // Toggle chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        tgl    = '0;
        tgl[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tgl[i] = tgl[i-1] & ((mode == MODE_UP) ? q[i-1] : ~q[i-1]);
        end
    end

    // Load is a set/clear per bit: J=d, K=~d.
    always_comb begin
        jv = '0;
        kv = '0;
        case (mode)
            MODE_JK: begin
                jv = j;
                kv = k;
            end
            MODE_UP, MODE_DOWN: begin
                jv = tgl;
                kv = tgl;
            end
            MODE_LOAD: begin
                jv = d;
                kv = ~d;
            end
            default: begin
                jv = '0;
                kv = '0;
            end
        endcase
    end

    always_comb begin
        if (en) begin
            q_next = (jv & ~q) | (~kv & q);
        end else begin
            q_next = q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RESET_VAL;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= (q_next != q);
        end
    end

    assign q_bar = ~q;
    assign tc    = en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~(|q)));

endmodule
